// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris placement search engine.
//   - tile-type codes (codes 7..15 are treated as O by the shape lookup)
//   - FSM state enum used by calc_unit
//   - shape_t / shape_of(): per (type, rotation) first occupied box column (x0),
//     occupied width (w) and bottom profile d[i] (height of column i's lowest
//     cell above the piece's lowest cell), using SRS 3x3/4x4 boxes.
//   - hmap_t: per-column surface height 0..2, index 0 = leftmost board column.
package tetris_pkg;

    localparam int BOARD_W = 10;

    localparam logic [3:0] TILE_I = 4'd0;
    localparam logic [3:0] TILE_O = 4'd1;
    localparam logic [3:0] TILE_T = 4'd2;
    localparam logic [3:0] TILE_S = 4'd3;
    localparam logic [3:0] TILE_Z = 4'd4;
    localparam logic [3:0] TILE_J = 4'd5;
    localparam logic [3:0] TILE_L = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2,
        WAIT = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]      x0;
        logic [2:0]      w;
        logic [3:0][1:0] d;   // d[0] is the leftmost occupied column
    } shape_t;

    typedef logic [BOARD_W-1:0][1:0] hmap_t;

    function automatic shape_t mk(input int x0, input int w,
                                  input int d0, input int d1, input int d2, input int d3);
        shape_t s;
        s.x0   = 2'(x0);
        s.w    = 3'(w);
        s.d[0] = 2'(d0);
        s.d[1] = 2'(d1);
        s.d[2] = 2'(d2);
        s.d[3] = 2'(d3);
        return s;
    endfunction

    function automatic shape_t shape_of(input logic [3:0] ttype, input logic [1:0] rot);
        shape_t s;
        case (ttype)
            TILE_I: case (rot)
                2'd1:    s = mk(2, 1, 0, 0, 0, 0);
                2'd3:    s = mk(1, 1, 0, 0, 0, 0);
                default: s = mk(0, 4, 0, 0, 0, 0);
            endcase
            TILE_O: s = mk(0, 2, 0, 0, 0, 0);
            TILE_T: case (rot)
                2'd0:    s = mk(0, 3, 0, 0, 0, 0);
                2'd1:    s = mk(1, 2, 0, 1, 0, 0);
                2'd2:    s = mk(0, 3, 1, 0, 1, 0);
                default: s = mk(0, 2, 1, 0, 0, 0);
            endcase
            TILE_S: case (rot)
                2'd1:    s = mk(1, 2, 1, 0, 0, 0);
                2'd3:    s = mk(0, 2, 1, 0, 0, 0);
                default: s = mk(0, 3, 0, 0, 1, 0);
            endcase
            TILE_Z: case (rot)
                2'd1:    s = mk(1, 2, 0, 1, 0, 0);
                2'd3:    s = mk(0, 2, 0, 1, 0, 0);
                default: s = mk(0, 3, 1, 0, 0, 0);
            endcase
            TILE_J: case (rot)
                2'd0:    s = mk(0, 3, 0, 0, 0, 0);
                2'd1:    s = mk(1, 2, 0, 2, 0, 0);
                2'd2:    s = mk(0, 3, 1, 1, 0, 0);
                default: s = mk(0, 2, 0, 0, 0, 0);
            endcase
            TILE_L: case (rot)
                2'd0:    s = mk(0, 3, 0, 0, 0, 0);
                2'd1:    s = mk(1, 2, 0, 0, 0, 0);
                2'd2:    s = mk(0, 3, 0, 1, 1, 0);
                default: s = mk(0, 2, 2, 0, 0, 0);
            endcase
            default: s = mk(0, 2, 0, 0, 0, 0);  // unused codes behave as O
        endcase
        return s;
    endfunction

endpackage

// File: rtl/calc_unit_if.sv
// Request/response bundle between the player FSM (master) and calc_unit (slave).
//   req            level request, held until resp is seen
//   tile           tile type code
//   row_hi/row_lo  2-row surface snapshot, bit9 = column 0
//   resp           one-cycle result strobe
//   opt_col        best anchor column (left edge of the tile box)
//   opt_rot        best rotation
interface calc_unit_if;
    logic       req;
    logic [3:0] tile;
    logic [9:0] row_hi;
    logic [9:0] row_lo;
    logic       resp;
    logic [3:0] opt_col;
    logic [1:0] opt_rot;

    modport master (output req, tile, row_hi, row_lo, input  resp, opt_col, opt_rot);
    modport slave  (input  req, tile, row_hi, row_lo, output resp, opt_col, opt_rot);
endinterface

// File: rtl/calc_score.sv
// Combinational scorer for one (rotation, column) placement candidate.
//   hmap   in   per-column surface height 0..2
//   col    in   anchor column of the tile box
//   ttype  in   tile type code
//   rot    in   rotation 0..3
//   valid  out  placement fits inside the board
//   land   out  landing height L (0..2)
//   holes  out  hole count H (0..16)
module calc_score
    import tetris_pkg::*;
(
    input  hmap_t              hmap,
    input  logic [3:0]         col,
    input  logic [3:0]         ttype,
    input  logic [1:0]         rot,
    output logic               valid,
    output logic signed [3:0]  land,
    output logic [4:0]         holes
);

    shape_t            shp;
    logic [4:0]        span;
    logic [3:0]        c;
    logic signed [3:0] hv [4];
    logic signed [3:0] gap;
    logic signed [3:0] term;
    logic signed [3:0] lmax;
    logic [4:0]        hsum;

    always_comb begin
        shp   = shape_of(ttype, rot);
        span  = {1'b0, col} + {3'b000, shp.x0} + {2'b00, shp.w};
        valid = (span <= 5'd10);
        c     = '0;
        gap   = '0;
        term  = '0;
        lmax  = '0;
        hsum  = '0;

        // Landing: the piece rests where the highest column contact stops it.
        for (int i = 0; i < 4; i++) begin
            c     = col + {2'b00, shp.x0} + 4'(i);
            hv[i] = '0;
            // Columns past the board edge only occur for invalid candidates.
            if (3'(i) < shp.w && c < 4'd10) begin
                hv[i] = $signed({2'b00, hmap[c]});
            end
            if (3'(i) < shp.w) begin
                gap = hv[i] - $signed({2'b00, shp.d[i]});
                if (gap > lmax) begin
                    lmax = gap;
                end
            end
        end

        // Holes: empty cells left between the piece's underside and the surface.
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < shp.w) begin
                term = lmax + $signed({2'b00, shp.d[i]}) - hv[i];
                hsum = hsum + {1'b0, $unsigned(term)};
            end
        end

        land  = lmax;
        holes = hsum;
    end

endmodule

// File: rtl/calc_unit.sv
// Placement search engine: on req, latches the tile and surface snapshot,
// scores all 40 (rotation, column) candidates one per cycle, and returns the
// best one (fewest holes, then lowest landing, earliest index on ties) with a
// one-cycle resp strobe.
//   clk    in   clock
//   reset  in   synchronous active-high reset, aborts a scan in progress
//   bus    slave side of calc_unit_if (req/tile/rows in, resp/opt_col/opt_rot out)
module calc_unit
    import tetris_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    calc_unit_if.slave  bus
);

    state_t            state;
    logic [3:0]        tile_q;
    hmap_t             hmap_q;
    logic [3:0]        col_idx;
    logic [1:0]        rot_idx;
    logic [3:0]        best_col;
    logic [1:0]        best_rot;
    logic [4:0]        best_h;
    logic signed [3:0] best_l;
    logic              resp_q;
    logic [3:0]        opt_col_q;
    logic [1:0]        opt_rot_q;

    logic              cand_valid;
    logic signed [3:0] cand_l;
    logic [4:0]        cand_h;
    logic              better;

    calc_score u_score (
        .hmap  (hmap_q),
        .col   (col_idx),
        .ttype (tile_q),
        .rot   (rot_idx),
        .valid (cand_valid),
        .land  (cand_l),
        .holes (cand_h)
    );

    // Strict improvement only, so the lowest-index candidate wins a tie.
    assign better = cand_valid &&
                    ((cand_h < best_h) || ((cand_h == best_h) && (cand_l < best_l)));

    // Snapshot latch: height map is derived once at request time.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req) begin
            tile_q <= bus.tile;
            for (int c = 0; c < BOARD_W; c++) begin
                hmap_q[c] <= {bus.row_hi[9-c], bus.row_lo[9-c] & ~bus.row_hi[9-c]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            col_idx   <= '0;
            rot_idx   <= '0;
            best_col  <= '0;
            best_rot  <= '0;
            best_h    <= '1;
            best_l    <= 4'sd7;
            resp_q    <= 1'b0;
            opt_col_q <= '0;
            opt_rot_q <= '0;
        end else begin
            resp_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        col_idx  <= '0;
                        rot_idx  <= '0;
                        best_col <= '0;
                        best_rot <= '0;
                        // Worse than any valid score, so the first valid candidate is taken.
                        best_h   <= '1;
                        best_l   <= 4'sd7;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (better) begin
                        best_col <= col_idx;
                        best_rot <= rot_idx;
                        best_h   <= cand_h;
                        best_l   <= cand_l;
                    end
                    if (col_idx == 4'd9) begin
                        col_idx <= '0;
                        if (rot_idx == 2'd3) begin
                            state <= DONE;
                        end else begin
                            rot_idx <= rot_idx + 2'd1;
                        end
                    end else begin
                        col_idx <= col_idx + 4'd1;
                    end
                end
                DONE: begin
                    opt_col_q <= best_col;
                    opt_rot_q <= best_rot;
                    resp_q    <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (!bus.req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp    = resp_q;
    assign bus.opt_col = opt_col_q;
    assign bus.opt_rot = opt_rot_q;

endmodule

// File: tb/tb_calc_unit.sv
// Testbench for calc_unit: directed cases plus random tiles/surfaces.
// The driver pushes the expected result and its due cycle into a queue when it
// raises req; an independent monitor on the falling edge pops and compares on
// every resp, and on all other cycles checks that the outputs hold the last result.
module tb_calc_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   fin   = 1'b0;
    int   cyc   = 0;

    calc_unit_if bus();

    calc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int col;
        int rot;
        int due;
    } exp_t;

    exp_t sb[$];

    // Shape table: x0*100000 + w*10000 + d0 d1 d2 d3 as decimal digits.
    int shape_code [7][4] = '{
        '{ 40000, 210000,  40000, 110000},   // I
        '{ 20000,  20000,  20000,  20000},   // O
        '{ 30000, 120100,  31010,  21000},   // T
        '{ 30010, 121000,  30010,  21000},   // S
        '{ 31000, 120100,  31000,  20100},   // Z
        '{ 30000, 120200,  31100,  20000},   // J
        '{ 30000, 120000,  30110,  22000}    // L
    };

    // Reference: try every placement, keep the best by (holes, landing, index).
    function automatic void ref_place(input int tile, input logic [9:0] hi, input logic [9:0] lo,
                                      output int bcol, output int brot);
        int t, code, x0, w, land, holes, bh, bl;
        int h [10];
        int d [4];
        t = (tile > 6) ? 1 : tile;
        for (int c = 0; c < 10; c++) h[c] = hi[9-c] ? 2 : (lo[9-c] ? 1 : 0);
        bh = 1000; bl = 1000; bcol = 0; brot = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 10; c++) begin
                code = shape_code[t][r];
                x0   = code / 100000;
                w    = (code / 10000) % 10;
                d[0] = (code / 1000) % 10;
                d[1] = (code / 100) % 10;
                d[2] = (code / 10) % 10;
                d[3] = code % 10;
                if (c + x0 + w <= 10) begin
                    land = 0;
                    for (int i = 0; i < w; i++)
                        if (h[c+x0+i] - d[i] > land) land = h[c+x0+i] - d[i];
                    holes = 0;
                    for (int i = 0; i < w; i++) holes += land + d[i] - h[c+x0+i];
                    if (holes < bh || (holes == bh && land < bl)) begin
                        bh = holes; bl = land; bcol = c; brot = r;
                    end
                end
            end
        end
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise req with the given data, scramble inputs mid-scan, hold req for
    // `hold` cycles after the resp cycle, then drop it.
    task automatic run_req(input logic [3:0] t, input logic [9:0] hi, input logic [9:0] lo,
                           input int ecol, input int erot, input int hold);
        exp_t e;
        step(1);
        bus.tile   = t;
        bus.row_hi = hi;
        bus.row_lo = lo;
        bus.req    = 1'b1;
        e.col = ecol;
        e.rot = erot;
        e.due = cyc + 42;
        sb.push_back(e);
        step(5);
        bus.tile   = 4'($urandom_range(0, 15));
        bus.row_hi = 10'($urandom_range(0, 1023));
        bus.row_lo = 10'($urandom_range(0, 1023));
        step(37 + hold);
        bus.req = 1'b0;
    endtask

    task automatic run_rand(input int hold);
        logic [3:0] t;
        logic [9:0] hi, lo;
        int ecol, erot;
        t  = 4'($urandom_range(0, 15));
        hi = 10'($urandom_range(0, 1023) & $urandom_range(0, 1023));
        lo = 10'($urandom_range(0, 1023));
        ref_place(int'(t), hi, lo, ecol, erot);
        run_req(t, hi, lo, ecol, erot, hold);
    endtask

    // Monitor / scoreboard: the only process that compares and counts.
    int n_vec = 0;
    int n_err = 0;
    int last_col = 0;
    int last_rot = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fin) begin
                n_vec++;
                if (sb.size() != 0) begin
                    n_err++;
                    $display("FAIL missing_resp: %0d results outstanding, want 0", sb.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
            if (reset) begin
                sb.delete();
                last_col = 0;
                last_rot = 0;
            end else if (bus.resp) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_resp: got resp=1 at cycle %0d col=%0d rot=%0d, want resp=0",
                             cyc, bus.opt_col, bus.opt_rot);
                end else begin
                    e = sb.pop_front();
                    n_vec++;
                    if (int'(bus.opt_col) != e.col || int'(bus.opt_rot) != e.rot) begin
                        n_err++;
                        $display("FAIL resp_value: got col=%0d rot=%0d, want col=%0d rot=%0d",
                                 bus.opt_col, bus.opt_rot, e.col, e.rot);
                    end
                    n_vec++;
                    if (cyc != e.due) begin
                        n_err++;
                        $display("FAIL resp_latency: got resp at cycle %0d, want cycle %0d", cyc, e.due);
                    end
                    last_col = e.col;
                    last_rot = e.rot;
                end
            end else begin
                n_vec++;
                if (int'(bus.opt_col) != last_col || int'(bus.opt_rot) != last_rot) begin
                    n_err++;
                    $display("FAIL hold_outputs: got col=%0d rot=%0d at cycle %0d, want col=%0d rot=%0d",
                             bus.opt_col, bus.opt_rot, cyc, last_col, last_rot);
                end
            end
        end
    end

    // Stimulus
    initial begin
        bus.req    = 1'b0;
        bus.tile   = '0;
        bus.row_hi = '0;
        bus.row_lo = '0;
        step(3);
        reset = 1'b0;
        step(2);

        // O on empty board, req held long after resp: exactly one resp.
        run_req(4'd1, 10'b0, 10'b0, 0, 0, 60);
        // Vertical I into the column-9 well.
        run_req(4'd0, 10'b1111111110, 10'b1111111110, 7, 1, 1);
        // T rotated into the one-deep notch at column 3.
        run_req(4'd2, 10'b0, 10'b1110111111, 2, 1, 1);
        // Unused tile code behaves as O.
        run_req(4'd9, 10'b0, 10'b0, 0, 0, 2);
        run_req(4'd2, 10'b0, 10'b1110111111, 2, 1, 2);

        // Reset 10 cycles into a scan: no resp, outputs cleared.
        step(1);
        bus.tile   = 4'd0;
        bus.row_hi = 10'b1111111110;
        bus.row_lo = 10'b1111111110;
        bus.req    = 1'b1;
        step(11);
        reset   = 1'b1;
        bus.req = 1'b0;
        step(1);
        reset = 1'b0;
        step(50);

        // Full-latency result after the abort, then back-to-back with new data.
        run_req(4'd0, 10'b1111111110, 10'b1111111110, 7, 1, 1);
        run_req(4'd1, 10'b0, 10'b0, 0, 0, 1);

        for (int k = 0; k < 30; k++) begin
            run_rand($urandom_range(1, 4));
        end

        step(10);
        fin = 1'b1;
        step(5);
        $display("FAIL watchdog: monitor did not finish, want summary");
        $fatal(1, "bench did not terminate");
    end

endmodule
